// File: rtl/conv_1_seq.sv
// Sequencer for one first-layer conv engine: streams the input map, runs the engine, stores results.
// Defining CONV_1_SEQ_WDOG_EN adds a RUN-cycle watchdog that sets the sticky err flag.
module conv_1_seq #(
    parameter int unsigned NUM_IN  = 9216,
    parameter int unsigned PRELOAD = 864,
    parameter int unsigned NUM_OUT = 7744,
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               go,
    input  logic               abort,
    output logic               rd_en,
    output logic [13:0]        rd_addr,
    input  logic signed [15:0] rd_data,
    output logic signed [15:0] eng_map_in,
    output logic               eng_start,
    output logic               eng_clr,
    input  logic signed [15:0] eng_map_out,
    input  logic               eng_save,
    output logic               wr_en,
    output logic [12:0]        wr_addr,
    output logic signed [15:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

    localparam logic [13:0] LastAddr    = 14'(NUM_IN - 1);
    // rd_data carries pixel PRELOAD while this address is being issued
    localparam logic [13:0] PreloadNext = 14'(PRELOAD + 1);
    localparam logic [13:0] NumOutCnt   = 14'(NUM_OUT);

    state_e             state_q, state_d;
    logic               rd_en_q, rd_en_d, rd_vld_q, rd_vld_d;
    logic [13:0]        rd_addr_q, rd_addr_d, wr_cnt_q, wr_cnt_d;
    logic signed [15:0] map_q, map_d, wr_data_q, wr_data_d;
    logic               wr_en_q, wr_en_d, clr_q, clr_d, done_q, done_d;
    logic [12:0]        wr_addr_q, wr_addr_d;
    logic               finish, timeout;

`ifdef CONV_1_SEQ_WDOG_EN
    localparam logic [14:0] LastTick = 15'(TIMEOUT - 1);
    logic [14:0] wdog_q, wdog_d;
    logic        err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d   = state_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        rd_vld_d  = rd_en_q;
        map_d     = rd_vld_q ? rd_data : '0;
        wr_cnt_d  = wr_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        clr_d     = 1'b0;
        done_d    = 1'b0;
        finish    = (state_q == StRun) && (wr_cnt_q == NumOutCnt);
        timeout   = 1'b0;
`ifdef CONV_1_SEQ_WDOG_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
        timeout = (state_q == StRun) && !finish && (wdog_q == LastTick);
`endif

        if (rd_en_q) begin
            if (rd_addr_q == LastAddr) rd_en_d = 1'b0;
            else                       rd_addr_d = rd_addr_q + 14'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d   = StFill;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    wr_cnt_d  = '0;
                    clr_d     = 1'b1;
`ifdef CONV_1_SEQ_WDOG_EN
                    wdog_d = '0;
                    err_d  = 1'b0;
`endif
                end
            end
            StFill: begin
                if (rd_addr_q == PreloadNext) state_d = StRun;
            end
            StRun: begin
`ifdef CONV_1_SEQ_WDOG_EN
                wdog_d = wdog_q + 15'd1;
`endif
                if (finish) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    clr_d   = 1'b1;
                end else if (timeout) begin
                    state_d = StIdle;
                    clr_d   = 1'b1;
`ifdef CONV_1_SEQ_WDOG_EN
                    err_d = 1'b1;
`endif
                end else if (eng_save) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_cnt_q[12:0];
                    wr_data_d = eng_map_out;
                    wr_cnt_d  = wr_cnt_q + 14'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // abort overrides go, saves, completion and timeout of the same cycle
        if (abort) begin
            state_d  = StIdle;
            clr_d    = 1'b1;
            done_d   = 1'b0;
            wr_en_d  = 1'b0;
            wr_cnt_d = wr_cnt_q;
`ifdef CONV_1_SEQ_WDOG_EN
            wdog_d = wdog_q;
            err_d  = err_q;
`endif
        end

        if (state_d != StFill && state_d != StRun) begin
            rd_en_d   = 1'b0;
            rd_addr_d = '0;
            rd_vld_d  = 1'b0;
            map_d     = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            map_q     <= '0;
            wr_cnt_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            clr_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_vld_q  <= rd_vld_d;
            map_q     <= map_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            clr_q     <= clr_d;
            done_q    <= done_d;
        end
    end

`ifdef CONV_1_SEQ_WDOG_EN
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign eng_map_in = map_q;
    assign eng_start  = (state_q == StRun);
    assign eng_clr    = clr_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q == StFill) || (state_q == StRun);
    assign done       = done_q;

endmodule

// File: tb/tb_conv_1_seq.sv
// Self-checking bench for conv_1_seq: RAM[a]=a input model, behavioural engine, write scoreboard.
module tb_conv_1_seq;

    logic               clk_in = 1'b0;
    logic               rst_n  = 1'b0;
    logic               go     = 1'b0;
    logic               abort  = 1'b0;
    logic               rd_en;
    logic [13:0]        rd_addr;
    logic signed [15:0] rd_data = '0;
    logic signed [15:0] eng_map_in;
    logic               eng_start, eng_clr;
    logic signed [15:0] eng_map_out = '0;
    logic               eng_save    = 1'b0;
    logic               wr_en;
    logic [12:0]        wr_addr;
    logic signed [15:0] wr_data;
    logic               busy, done, err;

    int          checks = 0;
    int          errors = 0;
    logic [28:0] sb[$];
    int          eng_delay = 4;
    bit          eng_en    = 1'b1;
    bit          ext_save  = 1'b0;
    logic signed [15:0] tbl [12] = '{16'sh0123, -16'sd5, 16'sh7fff, -16'sd32768,
                                     16'sh0000, 16'sh00ff, -16'sd1, 16'sh1000,
                                     16'sh0a5a, -16'sd300, 16'sh4321, 16'sh0007};

    conv_1_seq #(.NUM_IN(32), .PRELOAD(8), .NUM_OUT(12), .TIMEOUT(64)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .go         (go),
        .abort      (abort),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .eng_map_in (eng_map_in),
        .eng_start  (eng_start),
        .eng_clr    (eng_clr),
        .eng_map_out(eng_map_out),
        .eng_save   (eng_save),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Input RAM: data for the address seen in cycle t appears in cycle t+1
    initial begin
        logic        p;
        logic [13:0] a;
        forever begin
            @(negedge clk_in);
            p = rd_en;
            a = rd_addr;
            @(posedge clk_in);
            #1;
            rd_data = p ? 16'(a) : 16'sh7eef;
        end
    end

    // Engine: saves for 12 cycles starting eng_delay cycles after eng_start rises
    initial begin
        int run_cyc;
        int idx;
        run_cyc = 0;
        forever begin
            @(posedge clk_in);
            #2;
            eng_save = 1'b0;
            if (ext_save) begin
                eng_save    = 1'b1;
                eng_map_out = 16'sh1234;
            end else if (eng_start === 1'b1) begin
                idx = run_cyc - eng_delay;
                if (eng_en && idx >= 0 && idx < 12) begin
                    eng_save    = 1'b1;
                    eng_map_out = tbl[idx];
                    if (!abort) sb.push_back({13'(idx), tbl[idx]});
                end
                run_cyc++;
            end else begin
                run_cyc = 0;
            end
        end
    end

    // Write monitor
    initial begin
        logic [28:0] e;
        forever begin
            @(negedge clk_in);
            if (wr_en === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: write addr %0h data %0h, none expected at t=%0t",
                             wr_addr, wr_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", {19'd0, wr_addr}, {19'd0, e[28:16]});
                    chk("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
                end
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {1'b0, rd_en, rd_addr, eng_start, eng_clr, wr_en, wr_addr}, 0);
        chk({tag, "_data"}, {eng_map_in, wr_data}, 0);
        chk({tag, "_stat"}, {29'd0, busy, done, err}, 0);
    endtask

    // One full map; go at cycle 0 (and optionally a second, ignored go at cycle go2)
    task automatic run_map(input int d, input int go2);
        int fin;
        fin       = 24 + d;
        eng_delay = d;
        eng_en    = 1'b1;
        for (int r = 0; r <= fin + 2; r++) begin
            @(posedge clk_in);
            #1;
            go = (r == 0) || (r == go2);
            @(negedge clk_in);
            if (r > 0) begin
                chk("busy", busy, r < fin);
                chk("eng_start", eng_start, r >= 11 && r < fin);
                chk("done", done, r == fin);
                chk("eng_clr", eng_clr, r == 1 || r == fin);
                chk("rd_en", rd_en, r <= 32 && r < fin);
                if (r <= 32 && r < fin) chk("rd_addr", rd_addr, r - 1);
                chk("eng_map_in", {16'd0, eng_map_in},
                    (r >= 3 && r <= 34 && r < fin) ? r - 3 : 0);
                chk("err", err, 0);
            end
        end
        go = 1'b0;
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish at t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n_clr;
        int n_done;

        #2;
        chk_zero("reset");
        repeat (3) @(posedge clk_in);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk_in);

        run_map(4, -1);
        run_map(20, -1);

        // save pulse while idle must not write
        @(posedge clk_in);
        #1 ext_save = 1'b1;
        @(posedge clk_in);
        #1 ext_save = 1'b0;
        repeat (3) begin
            @(negedge clk_in);
            chk("idle_save_no_write", wr_en, 0);
        end

        run_map(4, 5);

        // abort after 5 writes
        eng_delay = 4;
        eng_en    = 1'b1;
        n_clr     = 0;
        n_done    = 0;
        for (int r = 0; r <= 30; r++) begin
            @(posedge clk_in);
            #1;
            go    = (r == 0);
            abort = (r == 20);
            @(negedge clk_in);
            if (r == 19) chk("busy_pre_abort", busy, 1);
            if (r == 21) chk("clr_after_abort", eng_clr, 1);
            if (r >= 20) n_done += done;
            if (r >= 21) begin
                n_clr += eng_clr;
                chk("busy_post_abort", busy, 0);
                chk("start_post_abort", eng_start, 0);
            end
        end
        abort = 1'b0;
        chk("abort_clr_pulses", n_clr, 1);
        chk("abort_no_done", n_done, 0);
        chk("abort_sb_drained", sb.size(), 0);
        run_map(4, -1);

        // asynchronous reset in the middle of FILL
        @(posedge clk_in);
        #1 go = 1'b1;
        @(posedge clk_in);
        #1 go = 1'b0;
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        chk("busy_pre_reset", busy, 1);
        @(posedge clk_in);
        #3 rst_n = 1'b0;
        #1;
        chk_zero("midfill_reset");
        repeat (2) @(negedge clk_in);
        @(posedge clk_in);
        #1 rst_n = 1'b1;
        run_map(4, -1);

        // watchdog: engine never saves
        eng_en = 1'b0;
        n_done = 0;
`ifdef CONV_1_SEQ_WDOG_EN
        for (int r = 0; r <= 80; r++) begin
            @(posedge clk_in);
            #1;
            go = (r == 0);
            @(negedge clk_in);
            n_done += done;
            if (r == 74) begin
                chk("wdog_err_pre", err, 0);
                chk("wdog_busy_pre", busy, 1);
            end
            if (r == 75) begin
                chk("wdog_err", err, 1);
                chk("wdog_busy_post", busy, 0);
                chk("wdog_clr", eng_clr, 1);
            end
            if (r == 80) chk("wdog_err_held", err, 1);
        end
        chk("wdog_no_done", n_done, 0);
        @(posedge clk_in);
        #1 go = 1'b1;
        @(posedge clk_in);
        #1 go = 1'b0;
        @(negedge clk_in);
        chk("err_cleared_by_go", err, 0);
        chk("busy_after_go", busy, 1);
`else
        for (int r = 0; r <= 150; r++) begin
            @(posedge clk_in);
            #1;
            go = (r == 0);
            @(negedge clk_in);
            n_done += done;
            if (r == 12 || r == 75 || r == 150) begin
                chk("nowdog_err", err, 0);
                chk("nowdog_busy", busy, 1);
            end
        end
        chk("nowdog_no_done", n_done, 0);
`endif
        @(posedge clk_in);
        #1 abort = 1'b1;
        @(posedge clk_in);
        #1 abort = 1'b0;
        @(negedge clk_in);
        chk("final_abort_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_1_seq.md
# conv_1_seq

Sequencer for one first-layer convolution engine: on a `go` request it streams the input feature map from the input RAM into the engine, holds the engine's `start` after its line buffer is primed, and writes every `save`-qualified result into the output RAM. It ends with a one-cycle `done` pulse to the layer scheduler. It sits between the layer scheduler, the two map RAMs and a conv engine such as the 9x9 first-layer unit.

## Interface
- `NUM_IN`, 9216: input pixels per map; valid read addresses are 0..NUM_IN-1.
- `PRELOAD`, 864: pixels fed with engine start low to fill the line buffer.
- `NUM_OUT`, 7744: results expected per map.
- `TIMEOUT`, 20000: maximum RUN cycles. Used only with the watchdog.
- `clk_in` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `go` in 1: single-cycle request to start a map.
- `abort` in 1: synchronous abort.
- `rd_en` out 1: input RAM read enable.
- `rd_addr` out 14: input RAM address.
- `rd_data` in 16: signed input RAM data, valid 1 cycle after `rd_en`.
- `eng_map_in` out 16: signed pixel to the engine.
- `eng_start` out 1: engine run enable.
- `eng_clr` out 1: active-high engine clear.
- `eng_map_out` in 16: signed engine result.
- `eng_save` in 1: engine result valid.
- `wr_en` out 1: output RAM write enable.
- `wr_addr` out 13: output RAM address.
- `wr_data` out 16: output RAM data.
- `busy` out 1: high in FILL and RUN.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky watchdog flag.

## Operation
- States: IDLE, FILL, RUN, DONE.
- IDLE -> FILL on `go`. This cycle clears the read counter, write counter and watchdog, pulses `eng_clr` for 1 cycle and clears `err`.
- FILL issues `rd_en=1` with `rd_addr` incrementing from 0, one address per cycle.
- FILL -> RUN when pixel PRELOAD reaches `eng_map_in`.
- Read-to-engine pipeline: `rd_addr=a` at cycle t, then `rd_data` at t+1, then registered `eng_map_in` at t+2.
- `eng_map_in` is 0 whenever no valid read is in flight.
- `eng_start` is 1 for every RUN cycle and 0 in every other state.
- Read addresses stop after NUM_IN-1: `rd_en` drops and zeros are fed while the engine drains.
- Every `eng_save=1` cycle in RUN registers a write: `wr_en=1`, `wr_data=eng_map_out`, `wr_addr` = write count. The count then increments.
- Saves outside RUN are ignored.
- RUN -> DONE on the cycle the NUM_OUT-th write is issued.
- DONE lasts 1 cycle: `done=1`, `eng_clr=1`, then IDLE.
- `abort` in any state forces IDLE next cycle with one `eng_clr` pulse and no `done`. `abort` wins over `go` and over saves in the same cycle.
- `go` outside IDLE is ignored.
- Reset values (asynchronous): state IDLE; every output and counter 0; `err=0`.
- Reset mid-map discards the map; after release the next `go` restarts from address 0.

## Timing
- `go` at cycle 0 gives `rd_addr=0, rd_en=1` at cycle 1, and pixel 0 on `eng_map_in` at cycle 3.
- `eng_start` rises at cycle 3+PRELOAD.
- Last read address NUM_IN-1 is issued at cycle NUM_IN.
- A save at cycle s gives the write at cycle s+1.
- The write of result NUM_OUT-1 at cycle w gives `done` at w+1, and `busy` low from w+1.
- Minimum gap between `done` and an accepted `go` is 1 cycle.

## Configuration
- `CONV_1_SEQ_WDOG_EN` defined: a RUN-cycle counter of 15 bits starts at 0 on entry to RUN.
  - Reaching TIMEOUT before the NUM_OUT-th write sets `err=1` and behaves as `abort`: `eng_clr` pulse, IDLE, no `done`.
  - `err` holds until the next accepted `go` or reset.
- `CONV_1_SEQ_WDOG_EN` undefined: no counter; `err` is tied 0; RUN waits indefinitely.

## Test plan
Bench parameters: NUM_IN=32, PRELOAD=8, NUM_OUT=12, TIMEOUT=64, with a behavioural engine that raises `eng_save` 4 cycles after `eng_start` for 12 cycles.
- Nominal map, RAM[a]=a:
  - `go` at cycle 0 -> `eng_map_in`=0..31 at cycles 3..34.
  - `eng_start` rises at cycle 11.
  - 12 writes to addresses 0..11 carry the engine values.
  - Single `done` pulse; `busy` is 0 afterwards.
- Ignored requests: `go` at cycles 0 and 5, and a save pulse in IDLE -> exactly one map runs and there is no write in IDLE.
- Abort: `abort` during RUN after 5 writes -> next cycle IDLE, one `eng_clr` pulse, no `done`. A new `go` restarts `wr_addr` at 0.
- Reset mid-FILL: assert `rst_n=0` asynchronously -> all outputs 0 immediately, without waiting for a clock edge. After release, a `go` runs a complete map.
- Watchdog with macro defined and an engine that never saves -> `err=1` 64 cycles after RUN entry, with `eng_clr` and no `done`.
- Watchdog with macro undefined -> `err` stays 0 and `busy` stays 1.
